barrett_reduce_pipe: RTL
========================

# barrett_reduce_pipe

Parametrised, pipelined Barrett modular reducer. It is the sequential successor of the combinational Barrett reduction in the multiplier datapath. A configuration handshake loads modulus `q`, and an internal serial divider computes `k` and `mu` once per modulus. A 4-stage valid/ready pipeline then reduces one `2W`-bit product per cycle to `z mod q`, using up to two conditional subtractions. It sits directly after the Vedic multiplier output register.

## Interface
- `W`, default 64: modulus width; product width is `2W`.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  synchronous, active-high reset.
- `cfg_valid`  in  1  new modulus offered.
- `cfg_ready`  out  1  modulus can be accepted.
- `cfg_q`  in  W  modulus.
- `cfg_done`  out  1  one-cycle pulse: `mu` is ready and the block is configured.
- `cfg_err`  out  1  one-cycle pulse: rejected modulus (`q < 2`).
- `in_valid` / `in_ready`  in / out  1  product handshake.
- `in_z`  in  2W  product to reduce.
- `out_valid` / `out_ready`  out / in  1  result handshake.
- `out_t`  out  W  `z mod q`.
- `out_err`  out  1  qualifies `out_t`; set when the `z` range was violated.
- `configured`  out  1  a valid `q`/`mu` is held.

## Operation
- **FSM states: UNCFG, DIV, RUN.** Reset enters UNCFG.
- **`cfg_ready`:**
  - In UNCFG it is 1.
  - In RUN it is 1 only when the pipeline is empty (no stage valid).
  - In DIV it is 0.
- **Config accept** (`cfg_valid && cfg_ready`):
  - If `q < 2`: pulse `cfg_err`, go to UNCFG, clear `configured`.
  - Otherwise: latch `q`, set `k` = bit length of `q` (1..W), clear `configured`, go to DIV.
- **DIV:** restoring division of `2^(2k)` by `q`. It runs exactly `2W+1` iterations (fixed, independent of `k`) and produces `mu = floor(4^k / q)`, which is `W+2` bits wide. On completion: go to RUN, set `configured`, pulse `cfg_done`.
- **Reduction** (HAC 14.42, `b = 2`), for `z < 4^k`:
  - `q1 = z >> (k-1)`
  - `q3 = (q1 * mu) >> (k+1)`
  - `r = z - q3*q`, computed in `W+2` bits
  - two compare/subtract stages, each doing `if r >= q: r -= q`
  - `r < q` is guaranteed after the second stage.
- **Range check:** if `z >= 4^k` (any bit at or above position `2k` is set), the result is forced to `out_t = 0` and `out_err = 1`. The slot still occupies the pipeline normally.
- **`in_ready`:** `(state == RUN) && (!out_valid || out_ready)`. Inputs are never accepted in UNCFG or DIV.
- **Stall:** a global enable equal to `!out_valid || out_ready` advances all stages together. Stage data holds while stalled.

## Timing
- **Reset values:**
  - `cfg_ready` = 1
  - `cfg_done` = 0, `cfg_err` = 0
  - `in_ready` = 0
  - `out_valid` = 0, `out_t` = 0, `out_err` = 0
  - `configured` = 0
  - all stage valids = 0
- **Config latency:** accept in cycle 0, `cfg_done` in cycle `2W+2`, `in_ready` may rise in cycle `2W+2`. For `W = 64` this is 130 cycles.
- **`cfg_err`:** pulses the cycle after accept.
- **Reduction latency:** 4 cycles. A `z` accepted in cycle n yields `out_valid` in cycle n+4 when there are no stalls. Throughput is 1 per cycle.
- **Stages:**
  - S1: register `q1*mu`
  - S2: register `r`
  - S3: correction 1
  - S4: correction 2, feeding the output register
- **Output stability:** `out_t` and `out_err` are stable while `out_valid && !out_ready`.
- **Reset mid-DIV or mid-pipeline:** all state is discarded, the FSM returns to UNCFG, and `configured` = 0. No `cfg_done` or `out_valid` appears afterwards until a new config completes.
- **`cfg_valid` while data is in flight:** not accepted. The pipeline drains first, and only then does `cfg_ready` go to 1.
- **`in_valid` and `cfg_valid` in the same cycle in RUN with an empty pipeline:** the input wins and the config waits.

## Structure
- **Package `barrett_pkg`:**
  - FSM state enum
  - `LAT = 4`
  - `function bitlen(q)`
  - `DIV_ITERS(W) = 2*W+1`
- **Sub-module `barrett_mu_div`:** serial restoring divider with ports start, k, q → done, mu. The top level holds the FSM, the pipeline and the handshakes.

## Test plan
- `W=16`, config `q=13` → `k=4`, `mu=19`, `cfg_done` at cycle 34. Then `z=168` → `out_t=12`; `z=255` → `out_t=8`; `z=0` → `out_t=0`.
- `W=16`, `q=65521` → `mu=65551`. `z=0xFFFFFFFF` → `out_t=224`. Also send 1000 random `z < q^2` back-to-back and check each result against a `%` model with latency exactly 4.
- `q=13`, `z=256` → `out_t=0`, `out_err=1`. The next `z=14` → `out_t=1`, `out_err=0`.
- Config `q=1` and `q=0` → `cfg_err` pulse, `configured=0`, `in_ready` stays 0.
- Hold `out_ready` low for 10 cycles with 6 inputs offered → at most 4 results are held plus the output register, no loss or duplication, `out_t` stays stable, and the sequence order is preserved.
- Assert `rst` during DIV at cycle 20, and separately with 3 products in flight → no `cfg_done` and no `out_valid` afterwards. Reconfigure with `q=7` and `z=50` → `out_t=1`.

Source files
------------

// File: rtl/barrett_pkg.sv
// Shared types and helpers for the pipelined Barrett reducer.
// Holds the FSM state type, the pipeline depth and the modulus bit-length helper.
package barrett_pkg;

  typedef enum logic [1:0] {StUncfg, StDiv, StRun} state_e;

  localparam int unsigned LAT   = 4;
  localparam int unsigned MAX_W = 128;

  function automatic int unsigned DIV_ITERS(input int unsigned w);
    return 2 * w + 1;
  endfunction

  // Index of the highest set bit plus one; 0 for an all-zero value.
  function automatic int unsigned bitlen(input logic [MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int unsigned i = 0; i < MAX_W; i++) begin
      if (v[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/barrett_mu_div.sv
// Serial restoring divider producing mu = floor(4^k / q).
// Always runs a fixed number of iterations so configuration latency does not depend on k.
module barrett_mu_div
  import barrett_pkg::*;
#(
  parameter int unsigned W = 64,
  localparam int unsigned KW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [KW-1:0] k,
  input  logic [W-1:0]  q,
  output logic          done,
  output logic [W+1:0]  mu
);

  localparam int unsigned Iters = DIV_ITERS(W);
  localparam int unsigned CW    = $clog2(Iters + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  rem_q, rem_d;
  logic [W-1:0]  q_q, q_d;
  logic [KW-1:0] k_q, k_d;
  logic [W+1:0]  quo_q, quo_d;
  logic          busy_q, busy_d;
  logic [W:0]    trial;
  logic          dbit;

  always_comb begin
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    q_d    = q_q;
    k_d    = k_q;
    quo_d  = quo_q;
    busy_d = busy_q;
    trial  = '0;
    dbit   = 1'b0;
    if (start) begin
      cnt_d  = CW'(Iters);
      rem_d  = '0;
      quo_d  = '0;
      q_d    = q;
      k_d    = k;
      busy_d = 1'b1;
    end else if (busy_q) begin
      // Dividend 2^(2k) has a single set bit; bits are consumed MSB first from position 2W.
      dbit  = ((32'(cnt_q) - 32'd1) == (32'(k_q) << 1));
      trial = {rem_q, dbit};
      if (trial >= {1'b0, q_q}) begin
        rem_d = W'(trial - {1'b0, q_q});
        quo_d = {quo_q[W:0], 1'b1};
      end else begin
        rem_d = trial[W-1:0];
        quo_d = {quo_q[W:0], 1'b0};
      end
      cnt_d  = cnt_q - CW'(1);
      busy_d = (cnt_q != CW'(1));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      rem_q  <= '0;
      q_q    <= '0;
      k_q    <= '0;
      quo_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      q_q    <= q_d;
      k_q    <= k_d;
      quo_q  <= quo_d;
      busy_q <= busy_d;
    end
  end

  // Asserted during the final iteration; mu is complete on the following cycle.
  assign done = busy_q && (cnt_q == CW'(1));
  assign mu   = quo_q;

endmodule

// File: rtl/barrett_reduce_pipe.sv
// Pipelined Barrett reducer: configuration FSM around a serial mu divider, then a
// 4-stage stall-together pipeline computing z mod q with two correction subtractions.
module barrett_reduce_pipe
  import barrett_pkg::*;
#(
  parameter int unsigned W = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           cfg_valid,
  output logic           cfg_ready,
  input  logic [W-1:0]   cfg_q,
  output logic           cfg_done,
  output logic           cfg_err,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_z,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_t,
  output logic           out_err,
  output logic           configured
);

  localparam int unsigned KW = $clog2(W + 1);
  localparam int unsigned PW = 2 * W + 3;

  state_e        state_q, state_d;
  logic [W-1:0]  mod_q, mod_d;
  logic [KW-1:0] k_q, k_d, k_new;
  logic          configured_q, configured_d;
  logic          cfg_done_q, cfg_done_d;
  logic          cfg_err_q, cfg_err_d;
  logic          div_start, div_done;
  logic [W+1:0]  mu;
  logic [MAX_W-1:0] q_ext;
  logic          cfg_acc, q_bad, en, pipe_empty;
  logic [LAT-1:0] vld_q, vld_d;

  logic [PW-1:0]  s1_prod_q, prod;
  logic [W+1:0]   s1_z_q;
  logic           s1_err_q, rng_err;
  logic [W+1:0]   s2_r_q, r_raw, q3;
  logic           s2_err_q;
  logic [W+1:0]   s3_r_q, r1, mod_ext;
  logic           s3_err_q;
  logic [W:0]     q1;
  logic [2*W-1:0] z_hi;
  logic [W-1:0]   r2, out_t_q, out_t_d;
  logic           out_err_q;

  barrett_mu_div #(
    .W(W)
  ) u_mu_div (
    .clk  (clk),
    .rst  (rst),
    .start(div_start),
    .k    (k_new),
    .q    (cfg_q),
    .done (div_done),
    .mu   (mu)
  );

  always_comb begin
    q_ext          = '0;
    q_ext[W-1:0]   = cfg_q;
    k_new          = KW'(bitlen(q_ext));
  end

  assign en         = !vld_q[LAT-1] || out_ready;
  assign pipe_empty = ~|vld_q;
  assign in_ready   = (state_q == StRun) && en;
  // A product offered alongside a config takes priority; config waits for a drained pipe.
  assign cfg_ready  = (state_q == StUncfg) || ((state_q == StRun) && pipe_empty && !in_valid);
  assign cfg_acc    = cfg_valid && cfg_ready;
  assign q_bad      = (cfg_q[W-1:1] == '0);

  always_comb begin
    state_d      = state_q;
    mod_d        = mod_q;
    k_d          = k_q;
    configured_d = configured_q;
    cfg_done_d   = 1'b0;
    cfg_err_d    = 1'b0;
    div_start    = 1'b0;
    unique case (state_q)
      StUncfg, StRun: begin
        if (cfg_acc) begin
          configured_d = 1'b0;
          if (q_bad) begin
            cfg_err_d = 1'b1;
            state_d   = StUncfg;
          end else begin
            mod_d     = cfg_q;
            k_d       = k_new;
            div_start = 1'b1;
            state_d   = StDiv;
          end
        end
      end
      StDiv: begin
        if (div_done) begin
          state_d      = StRun;
          configured_d = 1'b1;
          cfg_done_d   = 1'b1;
        end
      end
      default: state_d = StUncfg;
    endcase
  end

  always_comb begin
    mod_ext = {2'b00, mod_q};
    // Stage 1: q1 * mu plus range check on z against 4^k.
    q1      = (W + 1)'(in_z >> (32'(k_q) - 32'd1));
    prod    = {{(W + 2){1'b0}}, q1} * {{(W + 1){1'b0}}, mu};
    z_hi    = in_z >> (32'(k_q) << 1);
    rng_err = |z_hi;
    // Stage 2: true remainder is below 3q, so W+2 bit wraparound arithmetic is exact.
    q3      = (W + 2)'(s1_prod_q >> (32'(k_q) + 32'd1));
    r_raw   = s1_z_q - q3 * mod_ext;
    r1      = (s2_r_q >= mod_ext) ? (s2_r_q - mod_ext) : s2_r_q;
    r2      = (s3_r_q >= mod_ext) ? W'(s3_r_q - mod_ext) : s3_r_q[W-1:0];
    out_t_d = s3_err_q ? '0 : r2;
    vld_d   = en ? {vld_q[LAT-2:0], in_valid && in_ready} : vld_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StUncfg;
      mod_q        <= '0;
      k_q          <= '0;
      configured_q <= 1'b0;
      cfg_done_q   <= 1'b0;
      cfg_err_q    <= 1'b0;
      vld_q        <= '0;
      s1_prod_q    <= '0;
      s1_z_q       <= '0;
      s1_err_q     <= 1'b0;
      s2_r_q       <= '0;
      s2_err_q     <= 1'b0;
      s3_r_q       <= '0;
      s3_err_q     <= 1'b0;
      out_t_q      <= '0;
      out_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      mod_q        <= mod_d;
      k_q          <= k_d;
      configured_q <= configured_d;
      cfg_done_q   <= cfg_done_d;
      cfg_err_q    <= cfg_err_d;
      vld_q        <= vld_d;
      if (en) begin
        s1_prod_q <= prod;
        s1_z_q    <= in_z[W+1:0];
        s1_err_q  <= rng_err;
        s2_r_q    <= r_raw;
        s2_err_q  <= s1_err_q;
        s3_r_q    <= r1;
        s3_err_q  <= s2_err_q;
        out_t_q   <= out_t_d;
        out_err_q <= s3_err_q;
      end
    end
  end

  assign cfg_done   = cfg_done_q;
  assign cfg_err    = cfg_err_q;
  assign configured = configured_q;
  assign out_valid  = vld_q[LAT-1];
  assign out_t      = out_t_q;
  assign out_err    = out_err_q;

endmodule
